// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
// Shared RV32I definitions for the decode stage: default datapath widths,
// base opcode constants, the decoded opcode class and immediate format enums,
// and an opcode-to-class helper.
// No ports (package). Optional build macro used by the decode stage:
// ID_WB_BYPASS_EN.
// ----------------------------------------------------------------------------
package riscv_pkg;

   localparam int XLEN_DEFAULT      = 32;
   localparam int ADDR_SIZE_DEFAULT = 5;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef enum logic [3:0] {
      OPCLASS_LUI     = 4'd0,
      OPCLASS_AUIPC   = 4'd1,
      OPCLASS_JAL     = 4'd2,
      OPCLASS_JALR    = 4'd3,
      OPCLASS_BRANCH  = 4'd4,
      OPCLASS_LOAD    = 4'd5,
      OPCLASS_STORE   = 4'd6,
      OPCLASS_OP_IMM  = 4'd7,
      OPCLASS_OP      = 4'd8,
      OPCLASS_ILLEGAL = 4'd9
   } opclass_e;

   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5
   } imm_fmt_e;

   function automatic opclass_e decode_opclass(input logic [6:0] opcode);
      opclass_e cls;
      case (opcode)
         OPC_LUI:    cls = OPCLASS_LUI;
         OPC_AUIPC:  cls = OPCLASS_AUIPC;
         OPC_JAL:    cls = OPCLASS_JAL;
         OPC_JALR:   cls = OPCLASS_JALR;
         OPC_BRANCH: cls = OPCLASS_BRANCH;
         OPC_LOAD:   cls = OPCLASS_LOAD;
         OPC_STORE:  cls = OPCLASS_STORE;
         OPC_OP_IMM: cls = OPCLASS_OP_IMM;
         OPC_OP:     cls = OPCLASS_OP;
         default:    cls = OPCLASS_ILLEGAL;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/id_imm_gen.sv
// ----------------------------------------------------------------------------
// id_imm_gen
// Combinational RV32I immediate generator. Assembles the I/S/B/U/J immediate
// from the instruction word and sign-extends it from instr[31] to XLEN.
// Ports:
//   instr_i  in   32    instruction word
//   fmt_i    in   3     immediate format (imm_fmt_e)
//   imm_o    out  XLEN  sign-extended immediate (0 for IMM_NONE)
// Build macros: none (ID_WB_BYPASS_EN does not affect this block).
// ----------------------------------------------------------------------------
module id_imm_gen #(
   parameter int XLEN = riscv_pkg::XLEN_DEFAULT
) (
   input  logic [31:0]              instr_i,
   input  riscv_pkg::imm_fmt_e      fmt_i,
   output logic [XLEN-1:0]          imm_o
);
   import riscv_pkg::*;

   logic [31:0] imm32;

   always_comb begin
      imm32 = 32'd0;
      unique case (fmt_i)
         IMM_I:   imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
         IMM_S:   imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
         IMM_B:   imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                           instr_i[30:25], instr_i[11:8], 1'b0};
         IMM_U:   imm32 = {instr_i[31:12], 12'd0};
         IMM_J:   imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                           instr_i[20], instr_i[30:21], 1'b0};
         default: imm32 = 32'd0;
      endcase
   end

   // Widen to XLEN by replicating the sign bit of the 32-bit immediate.
   assign imm_o = {{(XLEN-31){imm32[31]}}, imm32[30:0]};

endmodule

// File: rtl/id_stage.sv
// ----------------------------------------------------------------------------
// id_stage
// RV32I instruction-decode stage. Decodes the fetched instruction, drives the
// register file read ports (combinational read), stalls on RAW hazards using
// a pending-write scoreboard plus a compare against the ID/EX destination,
// and registers the decoded instruction into the ID/EX register behind a
// valid/ready handshake. Synchronous active-high reset.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   if_valid/if_ready/if_instr/if_pc   fetch handshake and instruction
//   rf_read_enable1/2, rf_read_addr1/2 register file read request
//   rf_read_data1/2                 register file read data (same cycle)
//   wb_write_enable/addr/data       write-back commit
//   flush                           kill ID/EX contents, accept nothing
//   ex_valid/ex_ready               ID/EX handshake
//   ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rd, ex_rd_we,
//   ex_opclass, ex_funct3, ex_funct7b5, ex_illegal   decoded instruction
// Build macro: ID_WB_BYPASS_EN -- when defined, a write-back to a source
// register in the current cycle is forwarded into the operand and no longer
// counts as a scoreboard hazard, so the consumer issues in the write-back
// cycle instead of the one after.
// ----------------------------------------------------------------------------
module id_stage #(
   parameter int XLEN      = riscv_pkg::XLEN_DEFAULT,
   parameter int ADDR_SIZE = riscv_pkg::ADDR_SIZE_DEFAULT,
   parameter int NUM_REGS  = 2 ** ADDR_SIZE
) (
   input  logic                 clk,
   input  logic                 rst,

   input  logic                 if_valid,
   output logic                 if_ready,
   input  logic [31:0]          if_instr,
   input  logic [XLEN-1:0]      if_pc,

   output logic                 rf_read_enable1,
   output logic                 rf_read_enable2,
   output logic [ADDR_SIZE-1:0] rf_read_addr1,
   output logic [ADDR_SIZE-1:0] rf_read_addr2,
   input  logic [XLEN-1:0]      rf_read_data1,
   input  logic [XLEN-1:0]      rf_read_data2,

   input  logic                 wb_write_enable,
   input  logic [ADDR_SIZE-1:0] wb_write_addr,
   input  logic [XLEN-1:0]      wb_write_data,

   input  logic                 flush,

   output logic                 ex_valid,
   input  logic                 ex_ready,
   output logic [XLEN-1:0]      ex_pc,
   output logic [XLEN-1:0]      ex_rs1_data,
   output logic [XLEN-1:0]      ex_rs2_data,
   output logic [XLEN-1:0]      ex_imm,
   output logic [ADDR_SIZE-1:0] ex_rd,
   output logic                 ex_rd_we,
   output logic [3:0]           ex_opclass,
   output logic [2:0]           ex_funct3,
   output logic                 ex_funct7b5,
   output logic                 ex_illegal
);
   import riscv_pkg::*;

`ifdef ID_WB_BYPASS_EN
   localparam bit WB_BYPASS = 1'b1;
`else
   localparam bit WB_BYPASS = 1'b0;
`endif

   // ---------------------------------------------------------------- decode
   opclass_e               opclass;
   imm_fmt_e               imm_fmt;
   logic                   rs1_used, rs2_used, rd_writes, rd_we;
   logic [ADDR_SIZE-1:0]   rs1, rs2, rd;
   logic [XLEN-1:0]        imm;

   assign rs1 = if_instr[15 +: ADDR_SIZE];
   assign rs2 = if_instr[20 +: ADDR_SIZE];
   assign rd  = if_instr[7  +: ADDR_SIZE];

   always_comb begin
      opclass   = decode_opclass(if_instr[6:0]);
      imm_fmt   = IMM_NONE;
      rs1_used  = 1'b0;
      rs2_used  = 1'b0;
      rd_writes = 1'b0;
      unique case (opclass)
         OPCLASS_LUI:    begin imm_fmt = IMM_U; rd_writes = 1'b1; end
         OPCLASS_AUIPC:  begin imm_fmt = IMM_U; rd_writes = 1'b1; end
         OPCLASS_JAL:    begin imm_fmt = IMM_J; rd_writes = 1'b1; end
         OPCLASS_JALR:   begin imm_fmt = IMM_I; rd_writes = 1'b1; rs1_used = 1'b1; end
         OPCLASS_BRANCH: begin imm_fmt = IMM_B; rs1_used = 1'b1; rs2_used = 1'b1; end
         OPCLASS_LOAD:   begin imm_fmt = IMM_I; rd_writes = 1'b1; rs1_used = 1'b1; end
         OPCLASS_STORE:  begin imm_fmt = IMM_S; rs1_used = 1'b1; rs2_used = 1'b1; end
         OPCLASS_OP_IMM: begin imm_fmt = IMM_I; rd_writes = 1'b1; rs1_used = 1'b1; end
         OPCLASS_OP:     begin rd_writes = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1; end
         default:        begin imm_fmt = IMM_NONE; end
      endcase
      rd_we = rd_writes & (rd != '0);
   end

   id_imm_gen #(
      .XLEN (XLEN)
   ) u_imm_gen (
      .instr_i (if_instr),
      .fmt_i   (imm_fmt),
      .imm_o   (imm)
   );

   assign rf_read_enable1 = if_valid & rs1_used;
   assign rf_read_enable2 = if_valid & rs2_used;
   assign rf_read_addr1   = rs1;
   assign rf_read_addr2   = rs2;

   // ------------------------------------------------------------- registers
   logic [NUM_REGS-1:0]  sb_q, sb_d;
   logic                 ex_valid_q, ex_valid_d;
   logic [XLEN-1:0]      ex_pc_q, ex_pc_d;
   logic [XLEN-1:0]      ex_rs1_q, ex_rs1_d;
   logic [XLEN-1:0]      ex_rs2_q, ex_rs2_d;
   logic [XLEN-1:0]      ex_imm_q, ex_imm_d;
   logic [ADDR_SIZE-1:0] ex_rd_q, ex_rd_d;
   logic                 ex_rd_we_q, ex_rd_we_d;
   logic [3:0]           ex_opclass_q, ex_opclass_d;
   logic [2:0]           ex_funct3_q, ex_funct3_d;
   logic                 ex_funct7b5_q, ex_funct7b5_d;
   logic                 ex_illegal_q, ex_illegal_d;

   // --------------------------------------------------------- hazard / bypass
   logic           byp1, byp2;
   logic           haz1, haz2, hazard, accept;
   logic [XLEN-1:0] op1, op2;

   always_comb begin
      byp1 = WB_BYPASS & wb_write_enable & (wb_write_addr == rs1) & (rs1 != '0);
      byp2 = WB_BYPASS & wb_write_enable & (wb_write_addr == rs2) & (rs2 != '0);

      // A pending write is a hazard unless it is retiring right now on the
      // bypass path; an instruction still sitting in ID/EX always is.
      haz1 = rs1_used & (rs1 != '0) &
             ((sb_q[rs1] & ~byp1) | (ex_valid_q & ex_rd_we_q & (ex_rd_q == rs1)));
      haz2 = rs2_used & (rs2 != '0) &
             ((sb_q[rs2] & ~byp2) | (ex_valid_q & ex_rd_we_q & (ex_rd_q == rs2)));
      hazard = haz1 | haz2;

      op1 = '0;
      op2 = '0;
      if (rs1_used) op1 = byp1 ? wb_write_data : rf_read_data1;
      if (rs2_used) op2 = byp2 ? wb_write_data : rf_read_data2;
   end

   assign if_ready = (~ex_valid_q | ex_ready) & ~hazard & ~flush;
   assign accept   = if_valid & if_ready;

   // ----------------------------------------------------------- scoreboard
   always_comb begin
      sb_d = sb_q;
      if (wb_write_enable)
         sb_d[wb_write_addr] = 1'b0;
      // Applied after the clear so a same-register set in this cycle wins.
      if (ex_valid_q & ex_ready & ex_rd_we_q & ~flush)
         sb_d[ex_rd_q] = 1'b1;
      sb_d[0] = 1'b0;
   end

   // --------------------------------------------------------- ID/EX next
   always_comb begin
      ex_valid_d    = ex_valid_q;
      ex_pc_d       = ex_pc_q;
      ex_rs1_d      = ex_rs1_q;
      ex_rs2_d      = ex_rs2_q;
      ex_imm_d      = ex_imm_q;
      ex_rd_d       = ex_rd_q;
      ex_rd_we_d    = ex_rd_we_q;
      ex_opclass_d  = ex_opclass_q;
      ex_funct3_d   = ex_funct3_q;
      ex_funct7b5_d = ex_funct7b5_q;
      ex_illegal_d  = ex_illegal_q;
      if (flush) begin
         ex_valid_d = 1'b0;
      end else if (accept) begin
         ex_valid_d    = 1'b1;
         ex_pc_d       = if_pc;
         ex_rs1_d      = op1;
         ex_rs2_d      = op2;
         ex_imm_d      = imm;
         ex_rd_d       = rd;
         ex_rd_we_d    = rd_we;
         ex_opclass_d  = opclass;
         ex_funct3_d   = if_instr[14:12];
         ex_funct7b5_d = if_instr[30];
         ex_illegal_d  = (opclass == OPCLASS_ILLEGAL);
      end else if (ex_ready) begin
         ex_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sb_q          <= '0;
         ex_valid_q    <= 1'b0;
         ex_pc_q       <= '0;
         ex_rs1_q      <= '0;
         ex_rs2_q      <= '0;
         ex_imm_q      <= '0;
         ex_rd_q       <= '0;
         ex_rd_we_q    <= 1'b0;
         ex_opclass_q  <= 4'd0;
         ex_funct3_q   <= 3'd0;
         ex_funct7b5_q <= 1'b0;
         ex_illegal_q  <= 1'b0;
      end else begin
         sb_q          <= sb_d;
         ex_valid_q    <= ex_valid_d;
         ex_pc_q       <= ex_pc_d;
         ex_rs1_q      <= ex_rs1_d;
         ex_rs2_q      <= ex_rs2_d;
         ex_imm_q      <= ex_imm_d;
         ex_rd_q       <= ex_rd_d;
         ex_rd_we_q    <= ex_rd_we_d;
         ex_opclass_q  <= ex_opclass_d;
         ex_funct3_q   <= ex_funct3_d;
         ex_funct7b5_q <= ex_funct7b5_d;
         ex_illegal_q  <= ex_illegal_d;
      end
   end

   assign ex_valid    = ex_valid_q;
   assign ex_pc       = ex_pc_q;
   assign ex_rs1_data = ex_rs1_q;
   assign ex_rs2_data = ex_rs2_q;
   assign ex_imm      = ex_imm_q;
   assign ex_rd       = ex_rd_q;
   assign ex_rd_we    = ex_rd_we_q;
   assign ex_opclass  = ex_opclass_q;
   assign ex_funct3   = ex_funct3_q;
   assign ex_funct7b5 = ex_funct7b5_q;
   assign ex_illegal  = ex_illegal_q;

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage of the 5-stage RV32I pipeline, between fetch and execute.
- Decodes the fetched instruction and drives the register file's read ports, whose read is combinational in the same cycle.
- Detects RAW hazards with a pending-write scoreboard, stalling until the producing write-back has occurred.
- Registers the decoded operands into the ID/EX pipeline register behind a valid/ready handshake.

Parameters:
XLEN, 32, datapath width
ADDR_SIZE, 5, register address width
NUM_REGS, 32, architectural register count (fixed at 2**ADDR_SIZE)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
if_valid  in  1  fetch presents an instruction
if_ready  out  1  ID accepts this cycle
if_instr  in  32  instruction word
if_pc  in  XLEN  instruction PC
rf_read_enable1  out  1  register file port-1 read enable
rf_read_enable2  out  1  register file port-2 read enable
rf_read_addr1  out  ADDR_SIZE  rs1 address to register file
rf_read_addr2  out  ADDR_SIZE  rs2 address to register file
rf_read_data1  in  XLEN  register file port-1 read data
rf_read_data2  in  XLEN  register file port-2 read data
wb_write_enable  in  1  write-back commits this cycle
wb_write_addr  in  ADDR_SIZE  write-back destination
wb_write_data  in  XLEN  write-back data
flush  in  1  taken branch/jump in EX; kill ID/EX contents
ex_valid  out  1  ID/EX register holds an instruction
ex_ready  in  1  EX accepts
ex_pc  out  XLEN  registered PC
ex_rs1_data  out  XLEN  operand 1
ex_rs2_data  out  XLEN  operand 2
ex_imm  out  XLEN  sign-extended immediate
ex_rd  out  ADDR_SIZE  destination register
ex_rd_we  out  1  instruction writes rd
ex_opclass  out  4  decoded opcode class (opclass_e)
ex_funct3  out  3  funct3 field
ex_funct7b5  out  1  instr[30]
ex_illegal  out  1  unrecognised opcode

Behaviour:
- Reset: ex_valid=0, all ex_* outputs=0, scoreboard=0. A reset mid-stall drops the stalled instruction; fetch re-presents it.
- Decode is combinational from if_instr.
  - opclass: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, ILLEGAL.
  - Immediate formats: I, S, B, U, J; sign bit is instr[31]; B and J immediates have bit0=0.
- rs1_used: JALR, BRANCH, LOAD, STORE, OP_IMM, OP. rs2_used: BRANCH, STORE, OP.
  - rf_read_enableN = if_valid & rsN_used; rf_read_addrN = instr rs field.
- rd_we: all classes except BRANCH, STORE, ILLEGAL, and forced 0 when rd==0. ILLEGAL passes with ex_illegal=1.
- Hazard on rsN (only when rsN_used and rsN!=0):
  - scoreboard[rsN] is set, or
  - ex_valid & ex_rd_we & ex_rd==rsN.
- Handshake: if_ready = (!ex_valid | ex_ready) & !hazard & !flush.
- Load: on if_valid & if_ready, all ex_* outputs load at the next edge and ex_valid becomes 1 (1-cycle latency).
  - Else if ex_ready, ex_valid becomes 0.
  - Else the ID/EX register holds.
- Scoreboard:
  - Set bit ex_rd when ex_valid & ex_ready & ex_rd_we & !flush.
  - Clear bit wb_write_addr on wb_write_enable.
  - Same-register set and clear in the same cycle: set wins.
  - Bit 0 is always 0.
- Flush: at the next edge ex_valid becomes 0. That cycle: no scoreboard set, no new instruction accepted.
- A write-back in cycle N unstalls the dependent instruction in cycle N+1. The register file provides the new value in cycle N+1.

Optional Feature:
- Macro: ID_WB_BYPASS_EN.
- Defined:
  - If wb_write_enable & wb_write_addr==rsN (rsN!=0), operand N takes wb_write_data instead of rf_read_dataN.
  - The scoreboard component of the hazard is masked for that register, so the dependent instruction issues in the write-back cycle N.
  - The ex_rd comparison still applies.
- Undefined: no bypass; stall until cycle N+1 as above.

Decomposition:
- Shared package riscv_pkg:
  - opclass_e enum.
  - RV32I opcode constants (7'b0110111 LUI, etc.).
  - imm_fmt_e.
  - XLEN/ADDR_SIZE defaults.
- One sub-module, id_imm_gen: combinational immediate generator.
- Scoreboard stays inline.

Test Plan:
- addi x1,x0,5 with ex_ready=1 -> next cycle ex_valid=1, ex_imm=5, ex_rd=1, ex_rd_we=1, ex_opclass=OP_IMM.
- addi x1 then add x2,x1,x1 back-to-back; wb of x1 asserted 3 cycles after issue -> if_ready=0 until the cycle after wb (cycle of wb with ID_WB_BYPASS_EN); ex_rs1_data=ex_rs2_data=written value.
- ex_ready=0 for 4 cycles with ex_valid=1 -> if_ready=0 and ex_* stable throughout; the instruction is consumed on the first ex_ready=1.
- flush=1 while ex_valid=1, ex_rd=3 -> ex_valid=0 next cycle; scoreboard[3] stays 0; a following use of x3 does not stall.
- Issue of rd=4 and wb of x4 in the same cycle -> scoreboard[4]=1 afterwards (set wins).
- Instruction 32'hFFFFFFFF -> ex_illegal=1, ex_rd_we=0; beq with imm -2 -> ex_imm=32'hFFFFFFFE; any instruction with rd=0 -> ex_rd_we=0.
